wb_slave_arbiter: RTL and testbench



---
 rtl/wb_conmax_pkg.sv | 14 +
 rtl/wb_rr_pick.sv | 50 +++++
 rtl/wb_slave_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_slave_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_conmax_pkg.sv
// Shared types and defaults for the 8x8 Wishbone interconnect arbiters.
package wb_conmax_pkg;

    localparam int NUM_MASTERS_DFLT = 8;

    typedef logic [2:0] master_idx_t;
    typedef logic [1:0] prio_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational winner selection: highest priority class among eligible
// masters, then the first such master found searching upward from
// i_rr_last+1 (wrapping). Shared by the interconnect's arbiters.
module wb_rr_pick
    import wb_conmax_pkg::*;
#(
    parameter int NUM_MASTERS = NUM_MASTERS_DFLT,
    parameter int IDX_W       = 3,
    parameter int PRIO_W      = 2
) (
    input  logic [NUM_MASTERS-1:0]        i_elig,
    input  logic [NUM_MASTERS*PRIO_W-1:0] i_prio,
    input  logic [IDX_W-1:0]              i_rr_last,
    output logic [IDX_W-1:0]              o_win_idx,
    output logic                          o_win_valid
);

    logic [PRIO_W-1:0] w_max_prio;
    int                w_dist;
    int                w_best_dist;

    // Highest priority value present among the eligible masters.
    always_comb begin
        w_max_prio = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (i_elig[m] && (i_prio[m*PRIO_W +: PRIO_W] > w_max_prio)) begin
                w_max_prio = i_prio[m*PRIO_W +: PRIO_W];
            end
        end
    end

    // Among top-priority eligible masters, take the one closest after
    // i_rr_last in circular order (distance 0 means index i_rr_last+1).
    always_comb begin
        o_win_idx   = '0;
        o_win_valid = 1'b0;
        w_dist      = 0;
        w_best_dist = NUM_MASTERS;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            w_dist = (m + NUM_MASTERS - 1 - int'(i_rr_last)) % NUM_MASTERS;
            if (i_elig[m] && (i_prio[m*PRIO_W +: PRIO_W] == w_max_prio) &&
                (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                o_win_idx   = IDX_W'(m);
                o_win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_slave_arbiter.sv
// Per-slave Wishbone arbiter: priority + round-robin grant held for the
// whole cycle, with a watchdog that force-releases a stuck transfer.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ARB_IDLE | no master owns the slave; any eligible request wins next edge
//  ARB_OWN  | r_gnt_idx owns the slave until its req drops or watchdog fires
module wb_slave_arbiter
    import wb_conmax_pkg::*;
#(
    parameter int NUM_MASTERS    = NUM_MASTERS_DFLT,
    parameter int IDX_W          = 3,
    parameter int PRIO_W         = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_MASTERS-1:0]        req_i,
    input  logic [NUM_MASTERS*PRIO_W-1:0] prio_i,
    input  logic                          stb_i,
    input  logic                          term_i,
    output logic [NUM_MASTERS-1:0]        gnt_o,
    output logic [IDX_W-1:0]              gnt_idx_o,
    output logic                          gnt_valid_o,
    output logic                          tmo_err_o,
    output logic [IDX_W-1:0]              tmo_idx_o
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              WDOG_EN  = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_e             r_state;
    logic [IDX_W-1:0]       r_gnt_idx;
    logic [IDX_W-1:0]       r_rr_last;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_MASTERS-1:0] r_mask;
    logic                   r_tmo_err;
    logic [IDX_W-1:0]       r_tmo_idx;

    arb_state_e             w_state_nxt;
    logic [IDX_W-1:0]       w_gnt_idx_nxt;
    logic [IDX_W-1:0]       w_rr_last_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [NUM_MASTERS-1:0] w_mask_nxt;
    logic                   w_tmo_err_nxt;
    logic [IDX_W-1:0]       w_tmo_idx_nxt;

    logic [NUM_MASTERS-1:0] w_cur_onehot;
    logic                   w_cur_req;
    logic                   w_release;
    logic                   w_timeout;
    logic [NUM_MASTERS-1:0] w_elig;
    logic [IDX_W-1:0]       w_rr_base;
    logic [IDX_W-1:0]       w_win_idx;
    logic                   w_win_valid;

    // Release/timeout detection and the eligible set fed to the picker.
    // On a timeout the offending master is removed at the same edge its
    // mask bit is set, so it cannot win the re-arbitration it caused.
    // On any release the search starts just after the released index.
    always_comb begin
        w_cur_onehot = NUM_MASTERS'(1) << r_gnt_idx;
        w_cur_req    = |(req_i & w_cur_onehot);
        w_release    = (r_state == ARB_OWN) && !w_cur_req;
        w_timeout    = WDOG_EN && (r_state == ARB_OWN) && w_cur_req &&
                       stb_i && !term_i && (r_cnt == CNT_LAST);
        w_elig       = req_i & ~r_mask & ~(w_timeout ? w_cur_onehot : '0);
        w_rr_base    = (w_release || w_timeout) ? r_gnt_idx : r_rr_last;
    end

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W),
        .PRIO_W      (PRIO_W)
    ) u_pick (
        .i_elig      (w_elig),
        .i_prio      (prio_i),
        .i_rr_last   (w_rr_base),
        .o_win_idx   (w_win_idx),
        .o_win_valid (w_win_valid)
    );

    // State, grant, round-robin pointer, watchdog and mask registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ARB_IDLE;
            r_gnt_idx <= '0;
            r_rr_last <= IDX_W'(NUM_MASTERS - 1);
            r_cnt     <= '0;
            r_mask    <= '0;
            r_tmo_err <= 1'b0;
            r_tmo_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_rr_last <= w_rr_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mask    <= w_mask_nxt;
            r_tmo_err <= w_tmo_err_nxt;
            r_tmo_idx <= w_tmo_idx_nxt;
        end
    end

    // Next-state logic: grant, release/re-arbitration and watchdog count.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_idx_nxt = r_gnt_idx;
        w_rr_last_nxt = r_rr_last;
        w_cnt_nxt     = '0;
        w_mask_nxt    = (r_mask & req_i) | (w_timeout ? w_cur_onehot : '0);
        w_tmo_err_nxt = w_timeout;
        w_tmo_idx_nxt = w_timeout ? r_gnt_idx : r_tmo_idx;
        case (r_state)
            ARB_IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt   = ARB_OWN;
                    w_gnt_idx_nxt = w_win_idx;
                end
            end
            ARB_OWN: begin
                if (w_release || w_timeout) begin
                    w_rr_last_nxt = r_gnt_idx;
                    if (w_win_valid) begin
                        w_gnt_idx_nxt = w_win_idx;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                    end
                end else if (stb_i && !term_i) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        gnt_valid_o = (r_state == ARB_OWN);
        gnt_o       = gnt_valid_o ? w_cur_onehot : '0;
        gnt_idx_o   = r_gnt_idx;
        tmo_err_o   = r_tmo_err;
        tmo_idx_o   = r_tmo_idx;
    end

endmodule

// File: tb/tb_wb_slave_arbiter.sv
// Bench for wb_slave_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model through a scoreboard.
module tb_wb_slave_arbiter;

    localparam int N   = 8;
    localparam int TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  req_i;
    logic [15:0] prio_i;
    logic        stb_i;
    logic        term_i;
    logic [7:0]  gnt_o;
    logic [2:0]  gnt_idx_o;
    logic        gnt_valid_o;
    logic        tmo_err_o;
    logic [2:0]  tmo_idx_o;

    always #5 clk_i = ~clk_i;

    wb_slave_arbiter #(
        .NUM_MASTERS    (N),
        .IDX_W          (3),
        .PRIO_W         (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .prio_i      (prio_i),
        .stb_i       (stb_i),
        .term_i      (term_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .tmo_err_o   (tmo_err_o),
        .tmo_idx_o   (tmo_idx_o)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       tmo;
        logic [2:0] tidx;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state: owner is -1 when nobody holds the slave.
    int         m_owner;
    int         m_idx;
    int         m_rr;
    int         m_cnt;
    bit         m_tmo;
    int         m_tmo_idx;
    logic [7:0] m_mask;

    // Highest priority class first, then circular order after rr.
    function automatic int pick(logic [7:0] elig, logic [15:0] prio, int rr);
        for (int p = 3; p >= 0; p--) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (rr + k) % N;
                if (elig[i] && (int'(prio[i*2 +: 2]) == p)) return i;
            end
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [7:0] req,
                              input logic [15:0] prio, input logic stb, input logic term);
        logic [7:0] elig;
        logic [7:0] new_mask;
        bit         released;
        bit         timeout;
        int         w;
        if (rst) begin
            m_owner = -1; m_idx = 0; m_rr = N - 1; m_cnt = 0;
            m_mask = '0; m_tmo = 0; m_tmo_idx = 0;
            return;
        end
        elig     = req & ~m_mask;
        released = (m_owner >= 0) && !req[m_owner];
        timeout  = (m_owner >= 0) && !released && stb && !term && (m_cnt == TMO - 1);
        new_mask = m_mask & req;
        m_tmo    = timeout;
        if (timeout) begin
            new_mask[m_owner] = 1'b1;
            m_tmo_idx = m_owner;
        end
        if (m_owner < 0) begin
            w = pick(elig, prio, m_rr);
            if (w >= 0) begin m_owner = w; m_idx = w; end
            m_cnt = 0;
        end else if (released || timeout) begin
            if (timeout) elig[m_owner] = 1'b0;
            m_rr = m_owner;
            w = pick(elig, prio, m_owner);
            m_owner = w;
            if (w >= 0) m_idx = w;
            m_cnt = 0;
        end else begin
            m_cnt = (stb && !term) ? m_cnt + 1 : 0;
        end
        m_mask = new_mask;
    endtask

    // Drive one cycle of inputs, predict the result, wait for the edge.
    // On return the DUT outputs reflect these inputs.
    task automatic step(input logic rst, input logic [7:0] req, input logic [15:0] prio,
                        input logic stb, input logic term);
        exp_t e;
        rst_i = rst; req_i = req; prio_i = prio; stb_i = stb; term_i = term;
        model_step(rst, req, prio, stb, term);
        e.cyc   = cyc + 1;
        e.gnt   = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        e.idx   = 3'(m_idx);
        e.valid = (m_owner >= 0);
        e.tmo   = m_tmo;
        e.tidx  = 3'(m_tmo_idx);
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares each prediction in the cycle it targets.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                e = sb_q.pop_front();
                checks++;
                failures++;
                $display("FAIL sb_stale cycle=%0d expected_at=%0d", cyc, e.cyc);
            end
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                e = sb_q.pop_front();
                checks++;
                if (gnt_o !== e.gnt || gnt_idx_o !== e.idx || gnt_valid_o !== e.valid ||
                    tmo_err_o !== e.tmo || (e.tmo && tmo_idx_o !== e.tidx)) begin
                    failures++;
                    $display("FAIL sb_cycle%0d actual gnt=%h idx=%0d v=%b tmo=%b tidx=%0d required gnt=%h idx=%0d v=%b tmo=%b tidx=%0d",
                             cyc, gnt_o, gnt_idx_o, gnt_valid_o, tmo_err_o, tmo_idx_o,
                             e.gnt, e.idx, e.valid, e.tmo, e.tidx);
                end
            end
        end
    end

    initial begin
        logic [7:0]  req;
        logic [15:0] prio;
        int          h;
        int          prev;
        bit          seen;
        int          order[$];
        logic        rs;

        rst_i = 1'b1; req_i = '0; prio_i = '0; stb_i = 1'b0; term_i = 1'b0;
        model_step(1'b1, '0, '0, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;

        // Reset state, idle with no requests, then a single request.
        step(1, 8'h00, 16'h0, 0, 0);
        step(1, 8'h00, 16'h0, 0, 0);
        chk("rst_gnt", gnt_o, 8'h00);
        chk("rst_valid", gnt_valid_o, 1'b0);
        chk("rst_idx", gnt_idx_o, 3'd0);
        chk("rst_tmo", tmo_err_o, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(0, 8'h00, 16'h0, 0, 0);
            chk("idle_valid", gnt_valid_o, 1'b0);
        end
        step(0, 8'h04, 16'h0, 0, 0);
        chk("first_gnt", gnt_o, 8'h04);
        chk("first_idx", gnt_idx_o, 3'd2);

        // Equal priority round robin with back-to-back handover.
        step(1, 8'h00, 16'h0, 0, 0);
        h = 0; prev = 0; seen = 0;
        for (int c = 0; c < 40; c++) begin
            req = 8'hFF;
            if (seen && h >= 3) req[prev] = 1'b0;
            step(0, req, 16'h0, 0, 0);
            if (gnt_valid_o) begin
                if (!seen || int'(gnt_idx_o) != prev) begin
                    order.push_back(int'(gnt_idx_o));
                    prev = int'(gnt_idx_o);
                    h = 1;
                end else begin
                    h++;
                end
                seen = 1;
            end
            if (seen) chk("rr_no_idle", gnt_valid_o, 1'b1);
        end
        chk("rr_order_len", order.size() >= 9, 1'b1);
        for (int i = 0; i < 9 && i < order.size(); i++) chk("rr_order", order[i], i % 8);

        // Priority class is ignored while the owner holds the slave.
        step(1, 8'h00, 16'h5D55, 0, 0);
        step(0, 8'h01, 16'h5D55, 0, 0);
        chk("prio_own0", gnt_idx_o, 3'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h21, 16'h5D55, 0, 0);
            chk("prio_hold0", gnt_o, 8'h01);
        end
        step(0, 8'h20, 16'h5D55, 0, 0);
        chk("prio_to5", gnt_o, 8'h20);

        // Watchdog fires after 16 strobed cycles; master 3 stays masked.
        step(1, 8'h00, 16'h0, 0, 0);
        step(0, 8'h08, 16'h0, 0, 0);
        chk("tmo_own3", gnt_idx_o, 3'd3);
        for (int i = 1; i <= TMO; i++) begin
            step(0, 8'h09, 16'h0, 1, 0);
            if (i < TMO) chk("tmo_early", tmo_err_o, 1'b0);
        end
        chk("tmo_pulse", tmo_err_o, 1'b1);
        chk("tmo_idx", tmo_idx_o, 3'd3);
        chk("tmo_next_owner", gnt_o, 8'h01);
        step(0, 8'h09, 16'h0, 0, 0);
        chk("tmo_one_cycle", tmo_err_o, 1'b0);
        step(0, 8'h08, 16'h0, 0, 0);
        chk("tmo_masked_a", gnt_valid_o, 1'b0);
        step(0, 8'h08, 16'h0, 0, 0);
        chk("tmo_masked_b", gnt_valid_o, 1'b0);
        step(0, 8'h00, 16'h0, 0, 0);
        step(0, 8'h08, 16'h0, 0, 0);
        chk("tmo_regrant", gnt_o, 8'h08);

        // Termination on the limit cycle suppresses the timeout.
        step(1, 8'h00, 16'h0, 0, 0);
        step(0, 8'h08, 16'h0, 0, 0);
        for (int i = 1; i < TMO; i++) begin
            step(0, 8'h08, 16'h0, 1, 0);
            chk("term_pre", tmo_err_o, 1'b0);
        end
        step(0, 8'h08, 16'h0, 1, 1);
        chk("term_wins", tmo_err_o, 1'b0);
        for (int i = 1; i <= TMO; i++) begin
            step(0, 8'h08, 16'h0, 1, 0);
            chk("term_restart", tmo_err_o, (i == TMO));
        end

        // Reset in the middle of an ownership.
        step(1, 8'h00, 16'h0, 0, 0);
        step(0, 8'hFF, 16'h0, 0, 0);
        step(0, 8'hFF, 16'h0, 1, 0);
        step(0, 8'hFF, 16'h0, 1, 0);
        step(1, 8'hFF, 16'h0, 1, 0);
        chk("midrst_gnt", gnt_o, 8'h00);
        chk("midrst_tmo", tmo_err_o, 1'b0);
        step(0, 8'hFF, 16'h0, 0, 0);
        chk("midrst_first", gnt_o, 8'h01);

        // Random traffic against the model.
        req = 8'h00;
        prio = 16'($urandom);
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 15) == 0) prio = 16'($urandom);
            rs = ($urandom_range(0, 299) == 0);
            step(rs, req, prio, ($urandom_range(0, 7) != 0), ($urandom_range(0, 19) == 0));
        end

        step(0, 8'h00, 16'h0, 0, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
